// File: rtl/fft_radix2_core.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load, one butterfly per cycle, natural-order unload.
// Define FFT_STAGE_SCALE_EN to halve both butterfly outputs every stage (overall gain 1/N).
module fft_radix2_core #(
    parameter int N        = 64,
    parameter int LOG2N    = 6,
    parameter int D_WIDTH  = 16,
    parameter int TW_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [D_WIDTH-1:0]  in_re,
    input  logic [D_WIDTH-1:0]  in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [D_WIDTH-1:0]  out_re,
    output logic [D_WIDTH-1:0]  out_im,
    output logic                out_last,
    output logic                busy,
    output logic [LOG2N-2:0]    tw_idx,
    input  logic [TW_WIDTH-1:0] tw_re,
    input  logic [TW_WIDTH-1:0] tw_im
);
    localparam int BW   = LOG2N - 1;
    localparam int SW   = $clog2(LOG2N);
    localparam int PW   = D_WIDTH + TW_WIDTH;
    localparam int TWD  = D_WIDTH + 2;
    localparam int SUMW = D_WIDTH + 3;

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_e;

    state_e               state_q, state_d;
    logic [LOG2N-1:0]     n_q, n_d, m_q, m_d, m_inc;
    logic [BW-1:0]        bfly_q, bfly_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic                 in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d, busy_q, busy_d;
    logic [D_WIDTH-1:0]   out_re_q, out_re_d, out_im_q, out_im_d;
    logic [2*D_WIDTH-1:0] ram [N];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // Butterfly addressing: j = low stage bits of b, top inserts a 0 above them, bot a 1.
    logic [BW-1:0]    hi_mask, j_idx, tw_calc;
    logic [SW-1:0]    tw_shift;
    logic [LOG2N-1:0] top_addr, bot_addr;
    always_comb begin
        hi_mask  = {BW{1'b1}} << stage_q;
        j_idx    = bfly_q & ~hi_mask;
        top_addr = {bfly_q & hi_mask, 1'b0} | {1'b0, j_idx};
        bot_addr = top_addr | (LOG2N'(1) << stage_q);
        tw_shift = SW'(LOG2N - 1) - stage_q;
        tw_calc  = j_idx << tw_shift;
    end

    logic [2*D_WIDTH-1:0]        a_word, b_word;
    logic signed [D_WIDTH-1:0]   a_re, a_im, b_re, b_im;
    logic signed [TW_WIDTH-1:0]  w_re, w_im;
    logic signed [PW-1:0]        p_rr, p_ii, p_ri, p_ir;
    logic signed [PW:0]          t_re_full, t_im_full;
    logic signed [TWD-1:0]       t_re, t_im;
    logic signed [SUMW-1:0]      sum_re, sum_im, dif_re, dif_im;
    logic [D_WIDTH-1:0]          top_re, top_im, bot_re, bot_im;
    always_comb begin
        a_word    = ram[top_addr];
        b_word    = ram[bot_addr];
        a_re      = a_word[2*D_WIDTH-1:D_WIDTH];
        a_im      = a_word[D_WIDTH-1:0];
        b_re      = b_word[2*D_WIDTH-1:D_WIDTH];
        b_im      = b_word[D_WIDTH-1:0];
        w_re      = tw_re;
        w_im      = tw_im;
        p_rr      = PW'(b_re) * PW'(w_re);
        p_ii      = PW'(b_im) * PW'(w_im);
        p_ri      = PW'(b_re) * PW'(w_im);
        p_ir      = PW'(b_im) * PW'(w_re);
        t_re_full = (PW+1)'(p_rr) - (PW+1)'(p_ii);
        t_im_full = (PW+1)'(p_ri) + (PW+1)'(p_ir);
        // W^0 is exactly 1; bypass so Q1.15 rounding of 32767 cannot bleed in.
        if (tw_calc == '0) begin
            t_re = TWD'(b_re);
            t_im = TWD'(b_im);
        end else begin
            t_re = TWD'(t_re_full >>> (TW_WIDTH - 1));
            t_im = TWD'(t_im_full >>> (TW_WIDTH - 1));
        end
        sum_re = SUMW'(a_re) + SUMW'(t_re);
        sum_im = SUMW'(a_im) + SUMW'(t_im);
        dif_re = SUMW'(a_re) - SUMW'(t_re);
        dif_im = SUMW'(a_im) - SUMW'(t_im);
`ifdef FFT_STAGE_SCALE_EN
        top_re = D_WIDTH'(sum_re >>> 1);
        top_im = D_WIDTH'(sum_im >>> 1);
        bot_re = D_WIDTH'(dif_re >>> 1);
        bot_im = D_WIDTH'(dif_im >>> 1);
`else
        top_re = D_WIDTH'(sum_re);
        top_im = D_WIDTH'(sum_im);
        bot_re = D_WIDTH'(dif_re);
        bot_im = D_WIDTH'(dif_im);
`endif
    end

    logic [2*D_WIDTH-1:0] unload_word;
    always_comb begin
        m_inc       = m_q + LOG2N'(1);
        unload_word = ram[(state_q == S_UNLOAD) ? m_inc : '0];
        state_d     = state_q;
        n_d         = n_q;
        m_d         = m_q;
        bfly_d      = bfly_q;
        stage_d     = stage_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    n_d = n_q + LOG2N'(1);
                    if (&n_q) begin
                        state_d    = S_COMPUTE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                bfly_d = bfly_q + BW'(1);
                if (&bfly_q) begin
                    stage_d = stage_q + SW'(1);
                    if (stage_q == SW'(LOG2N - 1)) begin
                        stage_d     = '0;
                        state_d     = S_UNLOAD;
                        out_valid_d = 1'b1;
                        m_d         = '0;
                        out_re_d    = unload_word[2*D_WIDTH-1:D_WIDTH];
                        out_im_d    = unload_word[D_WIDTH-1:0];
                    end
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (&m_q) begin
                        state_d     = S_LOAD;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        in_ready_d  = 1'b1;
                        m_d         = '0;
                    end else begin
                        m_d        = m_inc;
                        out_re_d   = unload_word[2*D_WIDTH-1:D_WIDTH];
                        out_im_d   = unload_word[D_WIDTH-1:0];
                        out_last_d = &m_inc;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            n_q         <= '0;
            m_q         <= '0;
            bfly_q      <= '0;
            stage_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            m_q         <= m_d;
            bfly_q      <= bfly_d;
            stage_q     <= stage_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    // Top and bot of one butterfly are always distinct, so both writes land in the same cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid) ram[bitrev(n_q)] <= {in_re, in_im};
        if (state_q == S_COMPUTE) begin
            ram[top_addr] <= {top_re, top_im};
            ram[bot_addr] <= {bot_re, bot_im};
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign tw_idx    = (state_q == S_COMPUTE) ? tw_calc : '0;

endmodule

// File: tb/tb_fft_radix2_core.sv
// Bench for fft_radix2_core at N=8: arithmetic reference model feeds an expected-bin queue,
// a sink process applies out_ready patterns and compares each accepted bin.
module tb_fft_radix2_core;
    localparam int N = 8, LOG2N = 3, DW = 16, TWW = 16, W = 2*DW + 1;

    logic            clk = 1'b0, rst = 1'b0;
    logic            in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [DW-1:0]   in_re, in_im, out_re, out_im;
    logic [LOG2N-2:0] tw_idx;
    logic [TWW-1:0]  tw_re, tw_im;

    fft_radix2_core #(.N(N), .LOG2N(LOG2N), .D_WIDTH(DW), .TW_WIDTH(TWW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last), .busy(busy),
        .tw_idx(tw_idx), .tw_re(tw_re), .tw_im(tw_im)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // round(32767 * e^(-j*2*pi*k/8))
    function automatic logic [31:0] rom_word(input int k);
        case (k)
            0:       return {16'sd32767, 16'sd0};
            1:       return {16'sd23170, -16'sd23170};
            2:       return {16'sd0, -16'sd32767};
            default: return {-16'sd23170, -16'sd23170};
        endcase
    endfunction
    always_comb {tw_re, tw_im} = rom_word(int'(tw_idx));

    logic [W-1:0] exp_q[$];
    int n_checks = 0, n_pass = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int wrap16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int bitrev3(input int n);
        return (n % 2) * 4 + ((n / 2) % 2) * 2 + (n / 4) % 2;
    endfunction

    function automatic void model_push(input int xr[N], input int xi[N]);
        int mr[N], mi[N];
        int half, j, top, bot, k;
        longint wr, wi, ar, ai, br, bi, tr, ti;
        logic [31:0] w;
        logic signed [15:0] h;
        for (int n = 0; n < N; n++) begin
            mr[bitrev3(n)] = wrap16(xr[n]);
            mi[bitrev3(n)] = wrap16(xi[n]);
        end
        for (int s = 0; s < LOG2N; s++) begin
            for (int b = 0; b < N/2; b++) begin
                half = 1 << s;
                j    = b % half;
                top  = (b / half) * 2 * half + j;
                bot  = top + half;
                k    = j << (LOG2N - 1 - s);
                w    = rom_word(k);
                h    = w[31:16]; wr = h;
                h    = w[15:0];  wi = h;
                ar = mr[top]; ai = mi[top]; br = mr[bot]; bi = mi[bot];
                if (k == 0) begin
                    tr = br; ti = bi;
                end else begin
                    tr = (br * wr - bi * wi) >>> 15;
                    ti = (br * wi + bi * wr) >>> 15;
                end
`ifdef FFT_STAGE_SCALE_EN
                mr[top] = wrap16((ar + tr) >>> 1); mi[top] = wrap16((ai + ti) >>> 1);
                mr[bot] = wrap16((ar - tr) >>> 1); mi[bot] = wrap16((ai - ti) >>> 1);
`else
                mr[top] = wrap16(ar + tr); mi[top] = wrap16(ai + ti);
                mr[bot] = wrap16(ar - tr); mi[bot] = wrap16(ai - ti);
`endif
            end
        end
        for (int m = 0; m < N; m++) exp_q.push_back({(m == N-1), DW'(mr[m]), DW'(mi[m])});
    endfunction

    task automatic send_frame(input int xr[N], input int xi[N], input bit gaps, output int c_last);
        int n = 0;
        int guard = 0;
        c_last = -1;
        while (n < N && guard < 3000) begin
            @(negedge clk);
            guard++;
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_re    = DW'(xr[n]);
            in_im    = DW'(xi[n]);
            if (in_valid && in_ready) begin
                if (n == N-1) c_last = cyc;
                n++;
            end
        end
        check_eq("send_done", W'(n), W'(N));
        model_push(xr, xi);
    endtask

    task automatic wait_drain();
        int guard = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            guard++;
        end while ((exp_q.size() != 0 || out_valid) && guard < 1000);
        check_eq("drain_left", W'(exp_q.size()), W'(0));
        check_eq("idle_in_ready", W'({in_ready, busy, out_valid}), W'(3'b100));
    endtask

    // Sink: out_ready chosen first, so the handshake seen here is the one the next edge takes.
    int rdy_mode = 0, phase = 0;
    initial begin
        logic [W-1:0] cur, held;
        bit stalled;
        stalled   = 1'b0;
        held      = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (phase % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            phase++;
            if (rst && out_valid) begin
                cur = {out_last, out_re, out_im};
                if (stalled) check_eq("hold", cur, held);
                if (out_ready) begin
                    check_eq("bin_expected", W'(exp_q.size() > 0), W'(1));
                    if (exp_q.size() > 0) check_eq("bin", cur, exp_q.pop_front());
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int xr[N], xi[N], zero[N], c_last, first, k, s, b, half, j;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        for (int n = 0; n < N; n++) zero[n] = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", W'({in_ready, out_valid, out_last, busy, tw_idx}), W'(6'b100000));
        check_eq("rst_data", W'({out_re, out_im}), W'(0));
        rst = 1'b1;

        // Impulse with latency, busy and twiddle sequence checks.
        for (int n = 0; n < N; n++) xr[n] = (n == 0) ? 16384 : 0;
        send_frame(xr, zero, 1'b0, c_last);
        first = -1;
        k     = 0;
        for (int i = 0; i < 60 && first < 0; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) first = cyc;
            else if (busy) begin
                s    = k / 4;
                b    = k % 4;
                half = 1 << s;
                j    = b % half;
                check_eq("tw_idx", W'(tw_idx), W'(j << (LOG2N - 1 - s)));
                if (k == 0) check_eq("in_ready_compute", W'(in_ready), W'(0));
                k++;
            end
        end
        check_eq("latency", W'(first - c_last), W'(13));
        check_eq("compute_cycles", W'(k), W'(12));
        wait_drain();

        // DC frame under 1,0,0 backpressure with input gaps.
        rdy_mode = 1;
        for (int n = 0; n < N; n++) xr[n] = 2048;
        send_frame(xr, zero, 1'b1, c_last);
        wait_drain();

        // Random complex frames, random backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < N; n++) begin
                xr[n] = int'($urandom_range(0, 8000)) - 4000;
                xi[n] = int'($urandom_range(0, 8000)) - 4000;
            end
            send_frame(xr, xi, 1'b1, c_last);
            wait_drain();
        end

        // Reset pulse mid-COMPUTE discards the frame.
        rdy_mode = 0;
        for (int n = 0; n < N; n++) xr[n] = 1000 * (n + 1);
        send_frame(xr, zero, 1'b0, c_last);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b0;
        #1;
        exp_q.delete();
        check_eq("midrst_ctrl", W'({in_ready, out_valid, out_last, busy, tw_idx}), W'(6'b100000));
        check_eq("midrst_data", W'({out_re, out_im}), W'(0));
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < N; n++) xr[n] = (n == 0) ? 16384 : 0;
        send_frame(xr, zero, 1'b0, c_last);
        wait_drain();

        // Back-to-back: second frame queued while the first unloads.
        for (int n = 0; n < N; n++) begin
            xr[n] = int'($urandom_range(0, 20000)) - 10000;
            xi[n] = int'($urandom_range(0, 20000)) - 10000;
        end
        send_frame(xr, xi, 1'b0, c_last);
        for (int n = 0; n < N; n++) xr[n] = 1024;
        send_frame(xr, zero, 1'b0, c_last);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
